seq_magnitude_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. Scans DIGIT bits per cycle, starting at the MSB.
- Generalises the team's fixed 4-bit gate-level comparator in three ways: configurable width, optional signed compare, and valid/ready handshakes on input and output.
- Sits between operand producers and control logic where one wide compare per cycle would miss timing.

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/digit_compare.sv | 30 +++
 rtl/seq_magnitude_comparator.sv | 146 ++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package cmp_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic agb;
    logic aeb;
    logic alb;
  } result_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit operand still needs a one-bit digit index.
  function automatic int idx_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational DIGIT-bit unsigned compare: xnor equality chain with
// MSB-priority greater/less terms.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [DIGIT-1:0] bit_eq;
  logic             higher_eq;

  assign bit_eq = ~(da ^ db);

  always_comb begin
    gt        = 1'b0;
    lt        = 1'b0;
    higher_eq = 1'b1;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      gt        = gt | (higher_eq & da[i] & ~db[i]);
      lt        = lt | (higher_eq & ~da[i] & db[i]);
      higher_eq = higher_eq & bit_eq[i];
    end
    eq = higher_eq;
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator scanning DIGIT bits per cycle from the MSB.
// Define SEQ_CMP_EARLY_EXIT_EN to stop the scan at the first unequal digit.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operand pair
// SCAN  | comparing digit idx, MSB digit first
// DONE  | out_valid=1, flags held until out_ready
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             agb,
  output logic             aeb,
  output logic             alb
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int IDXW = idx_width(NDIG);
  localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NDIG - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0]  idx;
  result_t          res_q;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_gt, dig_eq, dig_lt;
  logic             last_dig;

`ifndef SEQ_CMP_EARLY_EXIT_EN
  logic decided;
`endif

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDXW'(i)) begin
        dig_a = a_q[i*DIGIT +: DIGIT];
        dig_b = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
    .da (dig_a),
    .db (dig_b),
    .gt (dig_gt),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  assign last_dig = (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SCAN;
`ifdef SEQ_CMP_EARLY_EXIT_EN
      SCAN: if (!dig_eq || last_dig) state_nxt = DONE;
`else
      SCAN: if (last_dig) state_nxt = DONE;
`endif
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    agb       = out_valid & res_q.agb;
    aeb       = out_valid & res_q.aeb;
    alb       = out_valid & res_q.alb;
  end

  // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      res_q   <= '0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
      decided <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a ^ (signed_mode ? SIGN_BIT : '0);
            b_q     <= b ^ (signed_mode ? SIGN_BIT : '0);
            idx     <= IDX_TOP;
            res_q   <= '0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            decided <= 1'b0;
`endif
          end
        end
        SCAN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
          if (!dig_eq)       res_q <= '{agb: dig_gt, aeb: 1'b0, alb: dig_lt};
          else if (last_dig) res_q <= '{agb: 1'b0, aeb: 1'b1, alb: 1'b0};
          else               idx   <= idx - IDXW'(1);
`else
          // First unequal digit decides; later digits cannot overwrite it.
          if (!decided && !dig_eq) begin
            res_q   <= '{agb: dig_gt, aeb: 1'b0, alb: dig_lt};
            decided <= 1'b1;
          end else if (!decided && last_dig) begin
            res_q <= '{agb: 1'b0, aeb: 1'b1, alb: 1'b0};
          end
          if (!last_dig) idx <= idx - IDXW'(1);
`endif
        end
        DONE: begin
          if (out_ready) begin
            res_q <= '0;
            idx   <= '0;
          end
        end
        default: begin
          res_q <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator (WIDTH=32, DIGIT=4).
// Expected latency follows SEQ_CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_seq_magnitude_comparator;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic agb;
    logic aeb;
    logic alb;
    int   lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             agb, aeb, alb;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .agb         (agb),
    .aeb         (aeb),
    .alb         (alb)
  );

  always #5 clk = ~clk;

  // Reference: native signed/unsigned compare, latency in edges from accept to seen-valid.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic ms);
    exp_t e;
    int   k;
    if (ms) begin
      e.agb = $signed(ma) > $signed(mb);
      e.alb = $signed(ma) < $signed(mb);
    end else begin
      e.agb = ma > mb;
      e.alb = ma < mb;
    end
    e.aeb = (ma == mb);
    k = NDIG;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    for (int d = 0; d < NDIG; d++)
      if (ma[d*DIGIT +: DIGIT] != mb[d*DIGIT +: DIGIT]) k = NDIG - d;
`endif
    e.lat = k + 1;
    return e;
  endfunction

  // Called at #1 after an edge with in_ready high; the next edge is the accept edge T.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts);
    a = ta;
    b = tb;
    signed_mode = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns the edge (relative to T) at which out_valid is first seen; 0 means timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      if (lat == 0) begin
        @(posedge clk);
        #1;
        if (out_valid) lat = j + 1;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, agb, aeb, alb} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b want=10000", {in_ready, out_valid, agb, aeb, alb});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string name, input logic [WIDTH-1:0] ta,
                         input logic [WIDTH-1:0] tb, input logic ts);
    exp_t e;
    int   lat;
    sb.push_back(model(ta, tb, ts));
    send(ta, tb, ts);
    wait_valid(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL %s_timeout out_valid never seen", name);
    end else begin
      if ({agb, aeb, alb} !== {e.agb, e.aeb, e.alb}) begin
        n_fail++;
        $display("FAIL %s_flags got=%b want=%b", name, {agb, aeb, alb}, {e.agb, e.aeb, e.alb});
      end
      n_cmp++;
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL %s_latency got=T+%0d want=T+%0d", name, lat, e.lat);
      end
      release_result();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s_release got=%b want=10", name, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_unsigned_early();
    run_one("unsigned_msb", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
  endtask

  task automatic test_equal();
    run_one("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_signed();
    run_one("signed_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    run_one("unsigned_neg", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_one("signed_both_neg", 32'h8000_0000, 32'hFFFF_FFFE, 1'b1);
  endtask

  task automatic test_last_digit();
    run_one("last_digit", 32'h1234_5670, 32'h1234_5671, 1'b0);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    logic [2:0] held;
    sb.push_back(model(32'h0000_0100, 32'h0000_0200, 1'b0));
    send(32'h0000_0100, 32'h0000_0200, 1'b0);
    wait_valid(lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat == 0) begin
      n_fail++;
      $display("FAIL bp_timeout out_valid never seen");
    end else begin
      held = {agb, aeb, alb};
      if (held !== {e.agb, e.aeb, e.alb}) begin
        n_fail++;
        $display("FAIL bp_flags got=%b want=%b", held, {e.agb, e.aeb, e.alb});
      end
      a = 32'hFFFF_FFFF;
      b = 32'h0;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, agb, aeb, alb} !== {2'b10, e.agb, e.aeb, e.alb}) begin
          n_fail++;
          $display("FAIL bp_hold cycle=%0d got=%b want=%b", c,
                   {out_valid, in_ready, agb, aeb, alb}, {2'b10, e.agb, e.aeb, e.alb});
        end
      end
      in_valid = 1'b0;
      release_result();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL bp_release got=%b want=10", {in_ready, out_valid});
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL bp_ignored_input got=%b want=10", {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    send(32'h1234_5670, 32'h1234_5671, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready got=%b want=1", in_ready);
    end
    repeat (12) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_result got=%b want=0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ra, rb;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ra : ((i % 3 == 1) ? (ra ^ (32'h1 << $urandom_range(31, 0))) : $urandom);
      run_one("b2b", ra, rb, i[0]);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_early();
    test_equal();
    test_signed();
    test_last_digit();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
